// File: rtl/hamming_pkg.sv
// Shared definitions for the extended-Hamming (SEC-DED) code family:
// code geometry helpers and the error classification type.
package hamming_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_DOUBLE = 2'd2
    } err_class_t;

    // Smallest r with 2^r >= data_bits + r + 1.
    function automatic int calc_parity_bits(input int data_bits);
        int r;
        r = 32'sd0;
        for (int k = 1; k < 31; k++) begin
            if ((r == 32'sd0) && ((32'sd2 ** k) >= (data_bits + k + 32'sd1))) begin
                r = k;
            end
        end
        return r;
    endfunction

    // True for 1, 2, 4, 8, ... (the Hamming check-bit positions).
    function automatic logic is_pow2(input int pos);
        return (pos > 32'sd0) && ((pos & (pos - 32'sd1)) == 32'sd0);
    endfunction

    // Codeword position carrying payload bit j: the j-th non-power-of-two
    // position, counting upward from position 1.
    function automatic int data_pos(input int j);
        int count;
        int pos;
        count = 32'sd0;
        pos   = 32'sd0;
        for (int i = 1; i < 1024; i++) begin
            if ((pos == 32'sd0) && !is_pow2(i)) begin
                if (count == j) begin
                    pos = i;
                end
                count = count + 32'sd1;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity / payload extraction for one
// extended-Hamming codeword. Bit 0 is overall parity, bit i is position i.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_BITS   = 4,
    localparam int PARITY_BITS = calc_parity_bits(DATA_BITS),
    localparam int CODE_BITS   = DATA_BITS + PARITY_BITS + 1
) (
    input  logic [CODE_BITS-1:0]   code,
    output logic [PARITY_BITS-1:0] syndrome,
    output logic                   parity,
    output logic [DATA_BITS-1:0]   data
);

    // Syndrome bit k folds in every position whose index has bit k set.
    always_comb begin
        syndrome = {PARITY_BITS{1'b0}};
        for (int i = 1; i < CODE_BITS; i++) begin
            for (int k = 0; k < PARITY_BITS; k++) begin
                if (((i >> k) & 32'sd1) != 32'sd0) begin
                    syndrome[k] = syndrome[k] ^ code[i];
                end else begin
                    syndrome[k] = syndrome[k];
                end
            end
        end
    end

    assign parity = ^code;

    for (genvar j = 0; j < DATA_BITS; j++) begin : g_extract
        localparam int POS = data_pos(j);
        assign data[j] = code[POS];
    end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SEC-DED decoder with valid/ready handshake and
// saturating corrected/uncorrectable word counters.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter  int DATA_BITS   = 4,
    parameter  int COUNT_BITS  = 16,
    localparam int PARITY_BITS = calc_parity_bits(DATA_BITS),
    localparam int CODE_BITS   = DATA_BITS + PARITY_BITS + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_BITS-1:0]   code_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_BITS-1:0]   data_out,
    output logic                   err_corrected,
    output logic                   err_uncorrectable,
    output logic [PARITY_BITS-1:0] syndrome,
    input  logic                   clear_counts,
    output logic [COUNT_BITS-1:0]  corr_count,
    output logic [COUNT_BITS-1:0]  uncorr_count
);

    // Syndromes at or above this value do not name a real position.
    localparam logic [PARITY_BITS:0]  SYN_LIMIT = CODE_BITS[PARITY_BITS:0];
    localparam logic [COUNT_BITS-1:0] COUNT_MAX = {COUNT_BITS{1'b1}};
    localparam logic [COUNT_BITS-1:0] COUNT_ONE = COUNT_BITS'(1'b1);

    logic                   s1_valid_r;
    logic [CODE_BITS-1:0]   s1_code_r;
    logic [PARITY_BITS-1:0] s1_syn_s;
    logic                   s1_par_s;
    logic [DATA_BITS-1:0]   s1_data_s;
    logic [DATA_BITS-1:0]   s1_fixed_s;
    err_class_t             s1_class_s;
    logic                   s1_corr_s;
    logic                   s1_unc_s;

    logic                   out_valid_r;
    logic [DATA_BITS-1:0]   data_out_r;
    logic                   err_corrected_r;
    logic                   err_uncorrectable_r;
    logic [PARITY_BITS-1:0] syndrome_r;
    logic [COUNT_BITS-1:0]  corr_count_r;
    logic [COUNT_BITS-1:0]  uncorr_count_r;

    logic                   s2_adv_s;
    logic                   s1_adv_s;
    logic                   out_xfer_s;

    assign s2_adv_s   = !out_valid_r || out_ready;
    assign s1_adv_s   = !s1_valid_r || s2_adv_s;
    assign out_xfer_s = out_valid_r && out_ready;

    // Stage 1: capture the incoming codeword when the stage can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_code_r  <= {CODE_BITS{1'b0}};
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_code_r <= code_in;
            end
        end
    end

    hamming_syndrome #(
        .DATA_BITS (DATA_BITS)
    ) u_syndrome (
        .code     (s1_code_r),
        .syndrome (s1_syn_s),
        .parity   (s1_par_s),
        .data     (s1_data_s)
    );

    // Classify the stage-1 word from syndrome and overall parity.
    always_comb begin
        s1_class_s = ERR_NONE;
        if (s1_par_s) begin
            if ({1'b0, s1_syn_s} < SYN_LIMIT) begin
                s1_class_s = ERR_SINGLE;
            end else begin
                s1_class_s = ERR_DOUBLE;
            end
        end else begin
            if (s1_syn_s != {PARITY_BITS{1'b0}}) begin
                s1_class_s = ERR_DOUBLE;
            end else begin
                s1_class_s = ERR_NONE;
            end
        end
    end

    // Decode the class into the two mutually exclusive flags.
    always_comb begin
        s1_corr_s = 1'b0;
        s1_unc_s  = 1'b0;
        case (s1_class_s)
            ERR_NONE: begin
                s1_corr_s = 1'b0;
                s1_unc_s  = 1'b0;
            end
            ERR_SINGLE: begin
                s1_corr_s = 1'b1;
                s1_unc_s  = 1'b0;
            end
            ERR_DOUBLE: begin
                s1_corr_s = 1'b0;
                s1_unc_s  = 1'b1;
            end
            default: begin
                s1_corr_s = 1'b0;
                s1_unc_s  = 1'b1;
            end
        endcase
    end

    // A single error at a payload position flips that payload bit back;
    // check-bit and parity-bit errors leave the payload untouched.
    for (genvar j = 0; j < DATA_BITS; j++) begin : g_fix
        localparam int POS = data_pos(j);
        assign s1_fixed_s[j] = s1_data_s[j]
                             ^ (s1_corr_s && (s1_syn_s == POS[PARITY_BITS-1:0]));
    end

    // Stage 2: register the decoded result; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r         <= 1'b0;
            data_out_r          <= {DATA_BITS{1'b0}};
            err_corrected_r     <= 1'b0;
            err_uncorrectable_r <= 1'b0;
            syndrome_r          <= {PARITY_BITS{1'b0}};
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                data_out_r          <= s1_fixed_s;
                err_corrected_r     <= s1_corr_s;
                err_uncorrectable_r <= s1_unc_s;
                syndrome_r          <= s1_syn_s;
            end
        end
    end

    // Saturating count of corrected words; clear wins over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_count_r <= {COUNT_BITS{1'b0}};
        end else if (clear_counts) begin
            corr_count_r <= {COUNT_BITS{1'b0}};
        end else if (out_xfer_s && err_corrected_r && (corr_count_r != COUNT_MAX)) begin
            corr_count_r <= corr_count_r + COUNT_ONE;
        end
    end

    // Saturating count of uncorrectable words; clear wins over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uncorr_count_r <= {COUNT_BITS{1'b0}};
        end else if (clear_counts) begin
            uncorr_count_r <= {COUNT_BITS{1'b0}};
        end else if (out_xfer_s && err_uncorrectable_r && (uncorr_count_r != COUNT_MAX)) begin
            uncorr_count_r <= uncorr_count_r + COUNT_ONE;
        end
    end

    assign in_ready          = s1_adv_s;
    assign out_valid         = out_valid_r;
    assign data_out          = data_out_r;
    assign err_corrected     = err_corrected_r;
    assign err_uncorrectable = err_uncorrectable_r;
    assign syndrome          = syndrome_r;
    assign corr_count        = corr_count_r;
    assign uncorr_count      = uncorr_count_r;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder: table-driven decode vectors on
// DATA_BITS=4 and DATA_BITS=8 instances, plus hand-written backpressure,
// counter saturation/clear and asynchronous reset sequences.
module tb_hamming_secded_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: DATA_BITS=4, COUNT_BITS=16
    logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
    logic [7:0]  code_a = 8'h00;
    logic [3:0]  data_a;
    logic        corr_a, unc_a, clear_a = 1'b0;
    logic [2:0]  syn_a;
    logic [15:0] ccnt_a, ucnt_a;

    // Instance B: DATA_BITS=4, COUNT_BITS=2
    logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
    logic [7:0]  code_b = 8'h00;
    logic [3:0]  data_b;
    logic        corr_b, unc_b, clear_b = 1'b0;
    logic [2:0]  syn_b;
    logic [1:0]  ccnt_b, ucnt_b;

    // Instance C: DATA_BITS=8, COUNT_BITS=16
    logic        in_valid_c = 1'b0, in_ready_c, out_valid_c, out_ready_c = 1'b1;
    logic [12:0] code_c = 13'h0000;
    logic [7:0]  data_c;
    logic        corr_c, unc_c, clear_c = 1'b0;
    logic [3:0]  syn_c;
    logic [15:0] ccnt_c, ucnt_c;

    hamming_secded_decoder #(.DATA_BITS(4), .COUNT_BITS(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .code_in(code_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .data_out(data_a), .err_corrected(corr_a), .err_uncorrectable(unc_a),
        .syndrome(syn_a), .clear_counts(clear_a), .corr_count(ccnt_a),
        .uncorr_count(ucnt_a)
    );

    hamming_secded_decoder #(.DATA_BITS(4), .COUNT_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .code_in(code_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .data_out(data_b), .err_corrected(corr_b), .err_uncorrectable(unc_b),
        .syndrome(syn_b), .clear_counts(clear_b), .corr_count(ccnt_b),
        .uncorr_count(ucnt_b)
    );

    hamming_secded_decoder #(.DATA_BITS(8), .COUNT_BITS(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .code_in(code_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .data_out(data_c), .err_corrected(corr_c), .err_uncorrectable(unc_c),
        .syndrome(syn_c), .clear_counts(clear_c), .corr_count(ccnt_c),
        .uncorr_count(ucnt_c)
    );

    typedef struct {
        logic        sel_c;   // 0: instance A, 1: instance C
        logic [15:0] code;
        logic [7:0]  data;
        logic [3:0]  syn;
        logic        corr;
        logic        unc;
        logic [15:0] ccnt;    // cumulative counts after this word transfers
        logic [15:0] ucnt;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // One word through an idle pipeline with OUT_READY=1.
    task automatic run_vec(input vec_t v, input int idx);
        if (!v.sel_c) begin
            in_valid_a = 1'b1;
            code_a     = v.code[7:0];
        end else begin
            in_valid_c = 1'b1;
            code_c     = v.code[12:0];
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        in_valid_c = 1'b0;
        @(posedge clk); #1;
        if (!v.sel_c) begin
            chk("a_out_valid", idx, 32'(out_valid_a), 32'd1);
            chk("a_data", idx, 32'(data_a), 32'(v.data));
            chk("a_syndrome", idx, 32'(syn_a), 32'(v.syn));
            chk("a_corr", idx, 32'(corr_a), 32'(v.corr));
            chk("a_uncorr", idx, 32'(unc_a), 32'(v.unc));
        end else begin
            chk("c_out_valid", idx, 32'(out_valid_c), 32'd1);
            chk("c_data", idx, 32'(data_c), 32'(v.data));
            chk("c_syndrome", idx, 32'(syn_c), 32'(v.syn));
            chk("c_corr", idx, 32'(corr_c), 32'(v.corr));
            chk("c_uncorr", idx, 32'(unc_c), 32'(v.unc));
        end
        @(posedge clk); #1;
        if (!v.sel_c) begin
            chk("a_corr_count", idx, 32'(ccnt_a), 32'(v.ccnt));
            chk("a_uncorr_count", idx, 32'(ucnt_a), 32'(v.ucnt));
        end else begin
            chk("c_corr_count", idx, 32'(ccnt_c), 32'(v.ccnt));
            chk("c_uncorr_count", idx, 32'(ucnt_c), 32'(v.ucnt));
        end
    endtask

    logic [7:0] bp_code [5];
    logic [3:0] bp_data [5];

    initial begin
        int   sent;
        int   rcv;
        logic held;
        logic [3:0] held_d;

        //            sel   code      data   syn   corr  unc   ccnt    ucnt
        vecs[0]  = '{1'b0, 16'h00AA, 8'h0B, 4'd0, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[1]  = '{1'b0, 16'h00EA, 8'h0B, 4'd6, 1'b1, 1'b0, 16'd1, 16'd0};
        vecs[2]  = '{1'b0, 16'h00AB, 8'h0B, 4'd0, 1'b1, 1'b0, 16'd2, 16'd0};
        vecs[3]  = '{1'b0, 16'h00E8, 8'h0F, 4'd7, 1'b0, 1'b1, 16'd2, 16'd1};
        vecs[4]  = '{1'b0, 16'h0000, 8'h00, 4'd0, 1'b0, 1'b0, 16'd2, 16'd1};
        vecs[5]  = '{1'b0, 16'h00A2, 8'h0B, 4'd3, 1'b1, 1'b0, 16'd3, 16'd1};
        vecs[6]  = '{1'b0, 16'h00A8, 8'h0B, 4'd1, 1'b1, 1'b0, 16'd4, 16'd1};
        vecs[7]  = '{1'b0, 16'h0080, 8'h00, 4'd7, 1'b1, 1'b0, 16'd5, 16'd1};
        vecs[8]  = '{1'b0, 16'h0003, 8'h00, 4'd1, 1'b0, 1'b1, 16'd5, 16'd2};
        vecs[9]  = '{1'b0, 16'h005A, 8'h05, 4'd0, 1'b0, 1'b0, 16'd5, 16'd2};
        vecs[10] = '{1'b0, 16'h007A, 8'h05, 4'd5, 1'b1, 1'b0, 16'd6, 16'd2};
        vecs[11] = '{1'b1, 16'h1000, 8'h00, 4'd12, 1'b1, 1'b0, 16'd1, 16'd0};
        vecs[12] = '{1'b1, 16'h0200, 8'h00, 4'd9, 1'b1, 1'b0, 16'd2, 16'd0};
        vecs[13] = '{1'b1, 16'h1005, 8'h80, 4'd14, 1'b0, 1'b1, 16'd2, 16'd1};
        vecs[14] = '{1'b1, 16'h0006, 8'h00, 4'd3, 1'b0, 1'b1, 16'd2, 16'd2};

        bp_code[0] = 8'hAA; bp_data[0] = 4'b1011;
        bp_code[1] = 8'h5A; bp_data[1] = 4'b0101;
        bp_code[2] = 8'h00; bp_data[2] = 4'b0000;
        bp_code[3] = 8'hFF; bp_data[3] = 4'b1111;
        bp_code[4] = 8'h0F; bp_data[4] = 4'b0001;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", -1, 32'(out_valid_a), 32'd0);
        chk("rst_data", -1, 32'(data_a), 32'd0);
        chk("rst_flags", -1, 32'({corr_a, unc_a}), 32'd0);
        chk("rst_syndrome", -1, 32'(syn_a), 32'd0);
        chk("rst_counts", -1, 32'({ccnt_a, ucnt_a}), 32'd0);
        chk("rst_in_ready", -1, 32'(in_ready_a), 32'd1);

        // Decode table
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: 5 clean words, consumer stalled for cycles 2..6
        sent = 0;
        rcv  = 0;
        held = 1'b0;
        held_d = 4'h0;
        for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
            out_ready_a = !(cyc >= 2 && cyc <= 6);
            in_valid_a  = (sent < 5);
            if (sent < 5) begin
                code_a = bp_code[sent];
            end
            @(negedge clk);
            chk("bp_in_ready", cyc, 32'(in_ready_a), 32'(out_ready_a));
            if (held) begin
                chk("bp_hold_valid", cyc, 32'(out_valid_a), 32'd1);
                chk("bp_hold_data", cyc, 32'(data_a), 32'(held_d));
            end
            if (out_valid_a && out_ready_a) begin
                chk("bp_order", rcv, 32'(data_a), 32'(bp_data[rcv]));
                chk("bp_flags", rcv, 32'({corr_a, unc_a}), 32'd0);
                rcv++;
            end
            held   = out_valid_a && !out_ready_a;
            held_d = data_a;
            if (in_valid_a && in_ready_a) begin
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        chk("bp_all_received", -1, 32'(rcv), 32'd5);
        @(posedge clk); #1;
        chk("bp_out_drained", -1, 32'(out_valid_a), 32'd0);
        chk("bp_counts_unchanged", -1, 32'({ccnt_a, ucnt_a}), {16'd6, 16'd2});

        // Saturation with COUNT_BITS=2
        for (int i = 0; i < 5; i++) begin
            in_valid_b = 1'b1;
            code_b     = 8'hEA;
            @(posedge clk); #1;
        end
        in_valid_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat_corr_count", -1, 32'(ccnt_b), 32'd3);
        chk("sat_uncorr_count", -1, 32'(ucnt_b), 32'd0);

        // Clear in the same cycle as a 6th correctable transfer
        in_valid_b = 1'b1;
        code_b     = 8'hEA;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        @(posedge clk); #1;
        chk("clr_out_valid", -1, 32'({out_valid_b, corr_b}), 32'd3);
        clear_b = 1'b1;
        @(posedge clk); #1;
        clear_b = 1'b0;
        chk("clr_corr_count", -1, 32'(ccnt_b), 32'd0);
        in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_clr_count", -1, 32'(ccnt_b), 32'd1);

        // Asynchronous reset with two words in flight
        out_ready_c = 1'b0;
        in_valid_c  = 1'b1;
        code_c      = 13'h1000;
        @(posedge clk); #1;
        code_c = 13'h1005;
        @(posedge clk); #1;
        in_valid_c = 1'b0;
        chk("full_out_valid", -1, 32'(out_valid_c), 32'd1);
        chk("full_in_ready", -1, 32'(in_ready_c), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", -1, 32'(out_valid_c), 32'd0);
        chk("arst_counts_c", -1, 32'({ccnt_c, ucnt_c}), 32'd0);
        chk("arst_counts_a", -1, 32'({ccnt_a, ucnt_a}), 32'd0);
        chk("arst_in_ready", -1, 32'(in_ready_c), 32'd1);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        out_ready_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_discarded", -1, 32'(out_valid_c), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
